// File: rtl/seq_arb_pkg.sv
// Shared definitions for the 4-input sequential arbiter and its requester agent.
package seq_arb_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [NUM_PORTS-1:0] port_vec_t;

  // True when exactly one bit of the vector is set.
  function automatic logic is_one_hot(input port_vec_t v);
    return (v != '0) && ((v & (v - port_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/seq_arb_req_port_ctr.sv
// One port's pending-request counter: saturating up/down, with drop reporting
// when an increment arrives while full and is not offset by a decrement.
module seq_arb_req_port_ctr #(
  parameter int CNT_BITS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic full,
  output logic drop
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0] count_q, count_d;
  logic                up, down;

  assign nonzero = (count_q != '0);
  assign full    = (count_q == CNT_MAX);

  // Next count: inc and dec together cancel; a lone inc saturates at max.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    drop    = inc & full & ~dec;
    up      = inc & ~dec & ~full;
    down    = dec & ~inc & nonzero;
    if (up) begin
      count_d = count_q + CNT_BITS'(1);
    end else if (down) begin
      count_d = count_q - CNT_BITS'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seq_arb_req_agent_4in.sv
// Requester-side agent for the 4-input sequential arbiter: per-port pending
// counters drive reqs, legal grants retire one request, illegal grants and
// dropped pushes raise sticky flags, and accepted grants are counted.
module seq_arb_req_agent_4in
  import seq_arb_pkg::*;
#(
  parameter int CNT_BITS = 3
) (
  input  logic      clk,
  input  logic      reset,
  input  port_vec_t push,
  input  port_vec_t grants,
  output port_vec_t reqs,
  output port_vec_t full,
  output logic      overflow,
  output logic      bad_grant,
  output logic [7:0] grant_count
);

  logic       legal;
  port_vec_t  dec_vec;
  port_vec_t  drop_vec;
  logic       overflow_q, overflow_d;
  logic       bad_grant_q, bad_grant_d;
  logic [7:0] grant_count_q, grant_count_d;

  // A grant counts only if it is one-hot and lands on a requesting port.
  assign legal   = is_one_hot(grants) && ((grants & reqs) != '0);
  assign dec_vec = legal ? grants : '0;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    seq_arb_req_port_ctr #(
      .CNT_BITS (CNT_BITS)
    ) u_ctr (
      .clk     (clk),
      .reset   (reset),
      .inc     (push[i]),
      .dec     (dec_vec[i]),
      .nonzero (reqs[i]),
      .full    (full[i]),
      .drop    (drop_vec[i])
    );
  end

  // Sticky flags accumulate; grant counter advances on each legal grant and wraps.
  always_comb begin
    overflow_d    = overflow_q | (|drop_vec);
    bad_grant_d   = bad_grant_q | ((grants != '0) & ~legal);
    grant_count_d = grant_count_q + {7'd0, legal};
  end

  // Flag and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q    <= 1'b0;
      bad_grant_q   <= 1'b0;
      grant_count_q <= '0;
    end else begin
      overflow_q    <= overflow_d;
      bad_grant_q   <= bad_grant_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign overflow    = overflow_q;
  assign bad_grant   = bad_grant_q;
  assign grant_count = grant_count_q;

endmodule

// File: tb/tb_seq_arb_req_agent_4in.sv
// Scoreboard bench for seq_arb_req_agent_4in: a driver applies directed and
// random stimulus at the falling edge and queues the expected post-edge state
// from a behavioural model; a monitor pops and compares after each rising edge.
module tb_seq_arb_req_agent_4in;

  localparam int MAXC = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] push = '0;
  logic [3:0] grants = '0;
  logic [3:0] reqs, full;
  logic       overflow, bad_grant;
  logic [7:0] grant_count;

  seq_arb_req_agent_4in dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .grants      (grants),
    .reqs        (reqs),
    .full        (full),
    .overflow    (overflow),
    .bad_grant   (bad_grant),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] reqs;
    logic [3:0] full;
    logic       overflow;
    logic       bad_grant;
    logic [7:0] grant_count;
  } obs_t;

  obs_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int cnt[4];
  bit m_ovf, m_bad;
  int m_gc;
  int accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_reqs();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (cnt[i] != 0);
    return r;
  endfunction

  function automatic logic [3:0] model_full();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (cnt[i] == MAXC);
    return f;
  endfunction

  // Variable-priority arbiter: first requester scanning upward from prio.
  function automatic logic [3:0] arb(input logic [3:0] r, input int prio);
    logic [3:0] g = '0;
    for (int k = 0; k < 4; k++) begin
      int p = (prio + k) % 4;
      if (r[p]) begin
        g[p] = 1'b1;
        break;
      end
    end
    return g;
  endfunction

  // Apply one cycle of stimulus and queue the state expected after the edge.
  task automatic step(input logic rst, input logic [3:0] p, input logic [3:0] g);
    logic [3:0] r;
    bit legal;
    obs_t e;
    @(negedge clk);
    reset  = rst;
    push   = p;
    grants = g;
    if (rst) begin
      foreach (cnt[i]) cnt[i] = 0;
      m_ovf = 0; m_bad = 0; m_gc = 0; accepted = 0;
    end else begin
      r = model_reqs();
      legal = ($countones(g) == 1) && ((g & r) != 0);
      if (g != 0 && !legal) m_bad = 1;
      for (int i = 0; i < 4; i++) begin
        bit d = legal && g[i];
        if (p[i]) begin
          if (cnt[i] == MAXC && !d) m_ovf = 1;
          else begin
            accepted++;
            if (!d) cnt[i]++;
          end
        end else if (d) begin
          cnt[i]--;
        end
      end
      if (legal) m_gc = (m_gc + 1) % 256;
    end
    e.reqs = model_reqs();
    e.full = model_full();
    e.overflow = m_ovf;
    e.bad_grant = m_bad;
    e.grant_count = 8'(m_gc);
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs shortly after each rising edge.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{reqs, full, overflow, bad_grant, grant_count};
        check("state", 32'(a), 32'(e));
      end
    end
  end

  initial begin
    int sum;
    int waited;
    // Reset.
    step(1, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000);

    // Single push then grant.
    step(0, 4'b0100, 4'b0000);
    step(0, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0100);

    // Saturation of port 0 then full drain.
    repeat (8) step(0, 4'b0001, 4'b0000);
    repeat (7) step(0, 4'b0000, 4'b0001);

    // Push and grant together on port 1 at max and at 2.
    step(1, 4'b0000, 4'b0000);
    repeat (7) step(0, 4'b0010, 4'b0000);
    step(0, 4'b0010, 4'b0010);
    repeat (5) step(0, 4'b0000, 4'b0010);
    step(0, 4'b0010, 4'b0010);
    repeat (2) step(0, 4'b0000, 4'b0010);

    // Multi-hot grant, then grant to an idle port.
    step(0, 4'b0011, 4'b0000);
    step(0, 4'b0000, 4'b0011);
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b0001, 4'b0000);
    step(0, 4'b0000, 4'b1000);

    // Build counts {3,1,0,5}, overflow=1, grant_count=9, then reset with pushes.
    step(1, 4'b0000, 4'b0000);
    repeat (8) step(0, 4'b0100, 4'b0000);
    repeat (7) step(0, 4'b0000, 4'b0100);
    repeat (5) step(0, 4'b0001, 4'b0000);
    repeat (2) step(0, 4'b0000, 4'b0001);
    step(0, 4'b1010, 4'b0000);
    repeat (4) step(0, 4'b1000, 4'b0000);
    step(1, 4'b1111, 4'b0000);
    step(0, 4'b0000, 4'b0000);

    // Closed loop with a behavioural variable-priority arbiter.
    for (int c = 0; c < 200; c++) begin
      logic [3:0] p = 4'($urandom_range(0, 15));
      int prio = $urandom_range(0, 3);
      step(0, p, arb(model_reqs(), prio));
    end
    step(0, 4'b0000, 4'b0000);

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    sum = 0;
    foreach (cnt[i]) sum += cnt[i];
    check("grant_identity", 32'(grant_count), 32'((accepted - sum) & 255));
    check("no_bad_grant", 32'(bad_grant), 32'(m_bad));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
